gcd_controller: RTL
===================

Name: gcd_controller

Overview:
- FSM controller that drives the 16-bit subtractive GCD datapath.
- Sequences the operand loads from data_in into the A and B registers.
- Iterates the subtract step using the gt/lt/eq comparator flags until the flags report equality, then signals done.
- Adds a start/busy/done handshake to the host, plus an iteration counter with a limit that catches non-terminating inputs such as a zero operand.

Parameters:
- CNT_W, 16, width of the iteration counter and of iter_count.
- MAX_ITER, 65535, maximum number of subtract steps before the run is aborted with err.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new GCD run; sampled only in IDLE
- gt  input  1  datapath flag: A > B
- lt  input  1  datapath flag: A < B
- eq  input  1  datapath flag: A == B
- ldA  output  1  load enable for datapath register A
- ldB  output  1  load enable for datapath register B
- sel1  output  1  subtractor minuend select: 0 = A, 1 = B
- sel2  output  1  subtractor subtrahend select: 0 = A, 1 = B
- sel_in  output  1  load bus select: 1 = data_in, 0 = subtractor output
- want_a  output  1  host must drive operand A on data_in this cycle
- want_b  output  1  host must drive operand B on data_in this cycle
- busy  output  1  a run is in progress
- done  output  1  one-cycle pulse at the end of a run; result sits in register A
- err  output  1  run aborted; held until the next accepted start
- iter_count  output  CNT_W  number of subtract steps taken in the current or last run

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high.
  - While rst is asserted: state = IDLE; all outputs = 0; iter_count = 0.
  - Reset asserted mid-run aborts the run. No done pulse is generated.
- Moore outputs: every output is a function of state only (registered state), so no control glitches reach the datapath.
- States and outputs:
  - IDLE: all controls 0, busy = 0. If start = 1, next state is LOAD_A, err is cleared and iter_count is cleared. err and iter_count otherwise retain their last-run values.
  - LOAD_A: ldA = 1, sel_in = 1, want_a = 1, busy = 1. Next state is LOAD_B.
  - LOAD_B: ldB = 1, sel_in = 1, want_b = 1, busy = 1. Next state is CHECK.
  - CHECK: controls 0, busy = 1. The flags are valid here because A and B are registered. Decision, in priority order:
    - eq = 1: next state DONE.
    - iter_count == MAX_ITER: set err, next state DONE.
    - gt = 1: next state SUB_A.
    - lt = 1: next state SUB_B.
    - no flag asserted (illegal): set err, next state DONE.
  - SUB_A (A <= A - B): ldA = 1, sel1 = 0, sel2 = 1, sel_in = 0. iter_count increments. Next state is CHECK.
  - SUB_B (B <= B - A): ldB = 1, sel1 = 1, sel2 = 0, sel_in = 0. iter_count increments. Next state is CHECK.
  - DONE: done = 1, busy = 1. Next state is IDLE.
- Timing: each subtract step costs 2 cycles (CHECK then SUB). If start is sampled at edge k, LOAD_A occupies cycle k+1, LOAD_B k+2, and the first CHECK k+3.
- Start handling: start while busy is ignored. start asserted in the DONE cycle is also ignored; start is accepted in the following IDLE cycle.
- Boundary conditions:
  - Both operands 0: eq → done, result 0, err = 0.
  - Exactly one operand 0: the run never converges and terminates via MAX_ITER with err = 1.
  - iter_count saturates at MAX_ITER and never wraps.
  - With the default MAX_ITER, the worst legal case (65535, 1 → 65534 steps) completes without err.

Decomposition:
- Shared package gcd_pkg holds:
  - the state encoding localparams IDLE, LOAD_A, LOAD_B, CHECK, SUB_A, SUB_B, DONE (3-bit binary);
  - the datapath width constant (16);
  - the select encodings SEL_A = 0, SEL_B = 1, SEL_DIN = 1.
- No sub-module. The counter is a few lines inline.
- A top-level gcd_top instantiating gcd_controller and the datapath is built separately.

Test Plan:
- Run 48, 18: start at edge k, A = 48 in the want_a cycle, B = 18 in the want_b cycle. Required: SUB_A at k+4 and k+6, SUB_B at k+8, SUB_A at k+10; done at k+12; iter_count = 4; datapath A = 6; err = 0.
- Run 7, 7: done at k+4; iter_count = 0; A = 7; no ldA/ldB pulse after LOAD_B.
- Run 5, 0 with MAX_ITER = 8: eight SUB_A pulses; done at k+20; err = 1; iter_count = 8. err must clear on the next start.
- Run 0, 0: done at k+4; err = 0; result 0.
- Pulse start during SUB_A of a 48, 18 run: ignored, and the original run completes unchanged. Assert rst in CHECK: all outputs go to 0 within the same cycle, with no done pulse. A new run of 9, 6 then yields 3 after 2 iterations.
- Force gt = lt = eq = 0 in CHECK: err = 1 and done pulses on the next cycle.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared constants for the subtractive GCD controller and datapath:
// state encodings, datapath width and mux select encodings.
package gcd_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_A = 3'd1;
  localparam logic [2:0] LOAD_B = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] SUB_A  = 3'd4;
  localparam logic [2:0] SUB_B  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  localparam logic SEL_A   = 1'b0;
  localparam logic SEL_B   = 1'b1;
  localparam logic SEL_DIN = 1'b1;
  localparam logic SEL_SUB = 1'b0;

endpackage

// File: rtl/gcd_controller_if.sv
// Host/datapath-facing signal bundle of the GCD controller.
// master = host + datapath side, slave = controller side.
interface gcd_controller_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             gt;
  logic             lt;
  logic             eq;
  logic             ldA;
  logic             ldB;
  logic             sel1;
  logic             sel2;
  logic             sel_in;
  logic             want_a;
  logic             want_b;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] iter_count;

  modport master (
    output start, gt, lt, eq,
    input  ldA, ldB, sel1, sel2, sel_in, want_a, want_b, busy, done, err, iter_count
  );

  modport slave (
    input  start, gt, lt, eq,
    output ldA, ldB, sel1, sel2, sel_in, want_a, want_b, busy, done, err, iter_count
  );
endinterface

// File: rtl/gcd_controller.sv
// Moore FSM sequencing operand loads and subtract steps of the 16-bit GCD datapath,
// with start/busy/done handshake and an iteration limit that flags runaway inputs.
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int          CNT_W    = 16,
  parameter int unsigned MAX_ITER = 65535
) (
  input logic              clk,
  input logic              rst,
  gcd_controller_if.slave  bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  logic [2:0]       state_q, state_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] iter_q, iter_d;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD_A;
          err_d   = 1'b0;
          iter_d  = '0;
        end
      end
      LOAD_A: state_d = LOAD_B;
      LOAD_B: state_d = CHECK;
      CHECK: begin
        if (bus.eq) begin
          state_d = DONE;
        end else if (iter_q == MAX_CNT) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (bus.gt) begin
          state_d = SUB_A;
        end else if (bus.lt) begin
          state_d = SUB_B;
        end else begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      SUB_A, SUB_B: begin
        state_d = CHECK;
        // Saturate rather than wrap; CHECK aborts the run once the limit is reached.
        if (iter_q != MAX_CNT) iter_d = iter_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    bus.ldA    = 1'b0;
    bus.ldB    = 1'b0;
    bus.sel1   = 1'b0;
    bus.sel2   = 1'b0;
    bus.sel_in = 1'b0;
    bus.want_a = 1'b0;
    bus.want_b = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state_q)
      LOAD_A: begin
        bus.ldA    = 1'b1;
        bus.sel_in = SEL_DIN;
        bus.want_a = 1'b1;
        bus.busy   = 1'b1;
      end
      LOAD_B: begin
        bus.ldB    = 1'b1;
        bus.sel_in = SEL_DIN;
        bus.want_b = 1'b1;
        bus.busy   = 1'b1;
      end
      CHECK: bus.busy = 1'b1;
      SUB_A: begin
        bus.ldA    = 1'b1;
        bus.sel1   = SEL_A;
        bus.sel2   = SEL_B;
        bus.sel_in = SEL_SUB;
        bus.busy   = 1'b1;
      end
      SUB_B: begin
        bus.ldB    = 1'b1;
        bus.sel1   = SEL_B;
        bus.sel2   = SEL_A;
        bus.sel_in = SEL_SUB;
        bus.busy   = 1'b1;
      end
      DONE: begin
        bus.done = 1'b1;
        bus.busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.err        = err_q;
  assign bus.iter_count = iter_q;

endmodule
